// File: rtl/tx_mem_stream_reader.sv
// Streams a block of words out of the TX memory read port in address order,
// hiding the 1-cycle read latency behind a 2-entry output FIFO.
module tx_mem_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] LAST_WORD = 1;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            fifo_count;
  logic [1:0]            occupancy;

  logic accept_start, abort_hit, pop, push, issue;

  assign accept_start = start && !abort && (state == IDLE || state == DONE);
  assign abort_hit    = abort && (state != IDLE);
  assign pop          = (fifo_count != 2'd0) && m_ready;
  assign push         = inflight;
  // Words in the FIFO plus the one in flight must never exceed the FIFO depth.
  assign occupancy    = fifo_count + {1'b0, inflight};
  assign issue        = (state == RUN) && !abort && (remaining != '0) &&
                        ((occupancy < 2'd2) || (occupancy == 2'd2 && pop));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A zero-length block spends one cycle in DRAIN so done lands two cycles after start.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept_start) state_next = (word_count == '0) ? DRAIN : RUN;
      RUN:   if (issue && remaining == LAST_WORD) state_next = DRAIN;
      DRAIN: if (!inflight && (fifo_count == 2'd0 || (fifo_count == 2'd1 && pop)))
               state_next = DONE;
      DONE:  state_next = accept_start ? ((word_count == '0) ? DRAIN : RUN) : IDLE;
      default: state_next = IDLE;
    endcase
    if (abort_hit) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
    end else begin
      if (accept_start) begin
        addr_q    <= start_addr;
        remaining <= word_count;
      end else if (issue) begin
        addr_q    <= addr_q + 1'b1;
        remaining <= remaining - 1'b1;
      end
      inflight <= issue;
    end
  end

  // NOTE: the two FIFO entries are reset because the head is visible on
  // m_data and must read 0 out of reset; larger RAMs would not be reset.
  always_ff @(posedge clk) begin
    if (reset || abort_hit) begin
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= mem_rdata;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_comb begin
    mem_wr    = 1'b0;
    mem_rd_en = issue;
    mem_addr  = addr_q;
    m_valid   = (fifo_count != 2'd0);
    m_data    = fifo_mem[rd_ptr];
    busy      = (state == RUN) || (state == DRAIN);
    done      = (state == DONE);
  end

endmodule

// File: tb/tb_tx_mem_stream_reader.sv
// Bench for tx_mem_stream_reader: memory model, expected-word and
// expected-address scoreboards, and per-scenario tasks.
module tb_tx_mem_stream_reader;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset, start, abort, m_ready;
  logic [AW-1:0] start_addr, mem_addr;
  logic [AW:0]   word_count;
  logic          mem_wr, mem_rd_en, m_valid, busy, done;
  logic [DW-1:0] mem_rdata, m_data;

  logic [DW-1:0] mem_model [DEPTH];

  tx_mem_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .word_count(word_count), .abort(abort), .mem_addr(mem_addr),
    .mem_wr(mem_wr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered read port: data for an address issued in cycle N appears in N+1.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem_model[mem_addr];

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] exp_data_q [$];
  logic [AW-1:0] exp_addr_q [$];

  int            start_cyc, first_valid_cyc, last_xfer_cyc, done_cyc;
  int            done_cnt, rd_cnt, xfer_cnt;
  logic          stall_seen;
  logic [DW-1:0] stall_data;

  task automatic sample();
    logic [DW-1:0] ed;
    logic [AW-1:0] ea;
    n_cmp++;
    if (rd_cnt - xfer_cnt > 2) begin
      n_bad++;
      $display("FAIL outstanding: %0d words buffered, limit 2", rd_cnt - xfer_cnt);
    end
    if (stall_seen) begin
      n_cmp++;
      if (m_valid !== 1'b1 || m_data !== stall_data) begin
        n_bad++;
        $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h",
                 m_valid, m_data, stall_data);
      end
    end
    if (mem_rd_en) begin
      rd_cnt++;
      n_cmp++;
      if (exp_addr_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_addr: unexpected read at %0d", mem_addr);
      end else begin
        ea = exp_addr_q.pop_front();
        if (mem_addr !== ea) begin
          n_bad++;
          $display("FAIL rd_addr: got %0d, required %0d", mem_addr, ea);
        end
      end
    end
    if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (m_valid && m_ready) begin
      xfer_cnt++;
      last_xfer_cyc = cyc;
      n_cmp++;
      if (exp_data_q.size() == 0) begin
        n_bad++;
        $display("FAIL stream_data: unexpected word %h", m_data);
      end else begin
        ed = exp_data_q.pop_front();
        if (m_data !== ed) begin
          n_bad++;
          $display("FAIL stream_data: got %h, required %h", m_data, ed);
        end
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      n_cmp++;
      if (busy !== 1'b0) begin
        n_bad++;
        $display("FAIL busy_at_done: busy=%b, required 0", busy);
      end
    end
    stall_seen = m_valid && !m_ready;
    stall_data = m_data;
  endtask

  // Sample mid-cycle, then return 1 time unit after the next rising edge.
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_metrics();
    first_valid_cyc = -1;
    last_xfer_cyc   = -1;
    done_cyc        = -1;
    done_cnt        = 0;
    rd_cnt          = 0;
    xfer_cnt        = 0;
    stall_seen      = 1'b0;
  endtask

  task automatic push_block(input int addr, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      exp_data_q.push_back(mem_model[(addr + i) % DEPTH]);
      exp_addr_q.push_back(AW'((addr + i) % DEPTH));
    end
  endtask

  task automatic run_block(input int addr, input int cnt, input bit rand_ready,
                           input int restart_at);
    clear_metrics();
    push_block(addr, cnt);
    start      = 1'b1;
    start_addr = AW'(addr);
    word_count = (AW+1)'(cnt);
    m_ready    = 1'b1;
    start_cyc  = cyc;
    tick();
    start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (done_cnt > 0) break;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (k == restart_at) begin
        start      = 1'b1;
        start_addr = AW'(9);
        word_count = (AW+1)'(3);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    if (done_cnt == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: no done for addr=%0d cnt=%0d", addr, cnt);
    end
    m_ready = 1'b1;
    repeat (3) tick();

    n_cmp++;
    if (done_cnt != 1) begin
      n_bad++;
      $display("FAIL done_count: got %0d pulses, required 1", done_cnt);
    end
    n_cmp++;
    if (exp_data_q.size() != 0 || exp_addr_q.size() != 0) begin
      n_bad++;
      $display("FAIL words_left: %0d words / %0d reads outstanding, required 0",
               exp_data_q.size(), exp_addr_q.size());
    end
    if (cnt == 0) begin
      n_cmp++;
      if (done_cyc != start_cyc + 2) begin
        n_bad++;
        $display("FAIL zero_done: done at +%0d, required +2", done_cyc - start_cyc);
      end
      n_cmp++;
      if (first_valid_cyc != -1 || rd_cnt != 0) begin
        n_bad++;
        $display("FAIL zero_quiet: reads=%0d valid_cyc=%0d, required 0 and none",
                 rd_cnt, first_valid_cyc);
      end
    end else begin
      n_cmp++;
      if (first_valid_cyc != start_cyc + 3) begin
        n_bad++;
        $display("FAIL first_valid: at +%0d, required +3", first_valid_cyc - start_cyc);
      end
      n_cmp++;
      if (done_cyc != last_xfer_cyc + 1) begin
        n_bad++;
        $display("FAIL done_timing: at %0d, required %0d", done_cyc, last_xfer_cyc + 1);
      end
      if (!rand_ready) begin
        n_cmp++;
        if (last_xfer_cyc - first_valid_cyc != cnt - 1) begin
          n_bad++;
          $display("FAIL throughput: span %0d cycles, required %0d",
                   last_xfer_cyc - first_valid_cyc + 1, cnt);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b1;
    start_addr = '0; word_count = '0;
    clear_metrics();
    repeat (3) tick();
    reset = 1'b0;
    n_cmp++;
    if ({mem_rd_en, m_valid, busy, done, mem_wr} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: rd_en,valid,busy,done,wr=%b, required 00000",
               {mem_rd_en, m_valid, busy, done, mem_wr});
    end
    n_cmp++;
    if (mem_addr !== '0) begin
      n_bad++;
      $display("FAIL reset_addr: got %0d, required 0", mem_addr);
    end
    n_cmp++;
    if (m_data !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got %h, required 0", m_data);
    end
  endtask

  task automatic test_cancel(input bit use_reset);
    clear_metrics();
    push_block(3, 8);
    start = 1'b1; start_addr = AW'(3); word_count = (AW+1)'(8); m_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 50 && xfer_cnt < 2; k++) tick();
    if (xfer_cnt < 2) begin
      n_cmp++; n_bad++;
      $display("FAIL cancel_timeout: %0d words seen, required 2", xfer_cnt);
    end
    if (use_reset) reset = 1'b1;
    else           abort = 1'b1;
    tick();
    abort = 1'b0;
    if (use_reset) tick();
    reset = 1'b0;
    exp_data_q.delete();
    exp_addr_q.delete();
    n_cmp++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL cancel_idle: valid=%b busy=%b, required 0 0", m_valid, busy);
    end
    repeat (4) tick();
    n_cmp++;
    if (done_cnt != 0) begin
      n_bad++;
      $display("FAIL cancel_done: got %0d pulses, required 0", done_cnt);
    end
    run_block(5, 3, 1'b0, -1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_model[i] = 32'hA0A0_0000 + DW'(i * 32'h0001_0011);
    test_reset();
    run_block(2, 4, 1'b0, -1);    // basic block and latency
    run_block(14, 4, 1'b0, -1);   // address wrap
    run_block(0, 16, 1'b1, -1);   // full memory under random backpressure
    run_block(7, 0, 1'b0, -1);    // zero-length block
    run_block(0, 4, 1'b0, 2);     // start while busy is ignored
    run_block(11, 5, 1'b1, -1);   // back-to-back with backpressure
    test_cancel(1'b0);            // abort mid-block
    test_cancel(1'b1);            // reset mid-block
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
